// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl: owns the single 8-bit RAM port, serving the load/store buffer (priority)
// and a byte-serial 4-byte instruction fetch. Optional IO store guard: MEMCTRL_IO_GUARD_EN.
module mem_arbiter_ctrl #(
    parameter logic [1:0] IO_HI_ADDR = 2'b11
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        control_hazard,
    input  logic        io_buffer_full,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    input  logic        slb_req,
    input  logic [31:0] slb_addr,
    input  logic        slb_wr,
    input  logic [7:0]  slb_dout,
    output logic        slb_grant,
    output logic [7:0]  slb_din,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_inst
);

    // Handshake: slb_req/slb_addr/slb_wr/slb_dout are held by the buffer until a cycle
    // where slb_grant=1; that cycle moves exactly one byte. A granted load returns its
    // byte on slb_din in the following cycle. if_req/if_addr are held until if_valid.

    typedef enum logic {F_IDLE, F_FETCH} fetch_state_e;
    typedef enum logic [1:0] {TAG_NONE, TAG_SLB, TAG_IF} tag_e;

    fetch_state_e state_q, state_d;
    tag_e         tag_q, tag_d;
    logic [1:0]   tag_idx_q, tag_idx_d;
    logic [31:0]  if_base_q, if_base_d;
    logic [2:0]   if_cnt_q, if_cnt_d;
    logic [31:0]  word_q, word_d;

    logic active, io_region, io_stall, io_hold;
    logic if_abort, if_capture, if_done, fetch_grant;

`ifdef MEMCTRL_IO_GUARD_EN
    logic io_idle_q, io_idle_d;
`else
    logic guard_unused;
    assign guard_unused = ^{io_buffer_full, io_region};
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= F_IDLE;
            tag_q     <= TAG_NONE;
            tag_idx_q <= 2'd0;
            if_base_q <= 32'd0;
            if_cnt_q  <= 3'd0;
            word_q    <= 32'd0;
`ifdef MEMCTRL_IO_GUARD_EN
            io_idle_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            tag_idx_q <= tag_idx_d;
            if_base_q <= if_base_d;
            if_cnt_q  <= if_cnt_d;
            word_q    <= word_d;
`ifdef MEMCTRL_IO_GUARD_EN
            io_idle_q <= io_idle_d;
`endif
        end
    end

    always_comb begin : grant_comb
        active    = !rst_in && rdy_in;
        io_region = (slb_addr[17:16] == IO_HI_ADDR);
`ifdef MEMCTRL_IO_GUARD_EN
        io_stall  = (slb_wr && io_region && io_buffer_full) || io_idle_q;
        io_hold   = io_idle_q;
`else
        io_stall  = 1'b0;
        io_hold   = 1'b0;
`endif
        // An abort discards the word immediately, including a byte arriving this cycle.
        if_abort    = (state_q == F_FETCH) &&
                      (control_hazard || !if_req || (if_addr != if_base_q));
        if_capture  = !rst_in && (state_q == F_FETCH) && (tag_q == TAG_IF) && !if_abort;
        if_done     = if_capture && (tag_idx_q == 2'd3);
        slb_grant   = active && slb_req && !io_stall;
        fetch_grant = active && !slb_grant && !io_hold && (state_q == F_FETCH) &&
                      !if_abort && (if_cnt_q < 3'd4);
    end

    always_comb begin : next_state_comb
        state_d   = state_q;
        tag_d     = TAG_NONE;
        tag_idx_d = tag_idx_q;
        if_base_d = if_base_q;
        if_cnt_d  = if_cnt_q;
        word_d    = word_q;
`ifdef MEMCTRL_IO_GUARD_EN
        io_idle_d = io_idle_q;
        if (rdy_in) begin
            io_idle_d = slb_grant && slb_wr && io_region;
        end
`endif
        case (state_q)
            F_IDLE: begin
                if (active && if_req && !control_hazard) begin
                    state_d   = F_FETCH;
                    if_base_d = if_addr;
                    if_cnt_d  = 3'd0;
                end
            end
            F_FETCH: begin
                if (if_abort || if_done) begin
                    state_d  = F_IDLE;
                    if_cnt_d = 3'd0;
                end else if (fetch_grant) begin
                    if_cnt_d = if_cnt_q + 3'd1;
                end
            end
            default: state_d = F_IDLE;
        endcase

        if (if_capture) begin
            word_d[{tag_idx_q, 3'b000} +: 8] = ram_din;
        end

        // The tag names who owns the byte that ram_din will carry next cycle.
        if (slb_grant) begin
            tag_d = slb_wr ? TAG_NONE : TAG_SLB;
        end else if (fetch_grant) begin
            tag_d     = TAG_IF;
            tag_idx_d = if_cnt_q[1:0];
        end
    end

    always_comb begin : output_comb
        ram_a    = 32'd0;
        ram_wr   = 1'b0;
        ram_dout = 8'd0;
        if (slb_grant) begin
            ram_a    = slb_addr;
            ram_wr   = slb_wr;
            ram_dout = slb_dout;
        end else if (fetch_grant) begin
            ram_a = if_base_q + 32'(if_cnt_q);
        end
        slb_din  = ram_din;
        if_valid = if_done;
        if_inst  = if_done ? {ram_din, word_q[23:0]} : word_q;
    end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Bench for mem_arbiter_ctrl: behavioural RAM, reference memory and expected-value queues
// for load bytes and fetched words, plus directed timing checks on the RAM port.
module tb_mem_arbiter_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        control_hazard;
    logic        io_buffer_full;
    logic [7:0]  ram_din = 8'h00;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        slb_req;
    logic [31:0] slb_addr;
    logic        slb_wr;
    logic [7:0]  slb_dout;
    logic        slb_grant;
    logic [7:0]  slb_din;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_inst;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  ref_mem [logic [31:0]];
    logic [7:0]  env_mem [logic [31:0]];
    logic [31:0] exp_inst_q[$];
    logic [7:0]  exp_slb_q[$];
    logic        slb_rd_pend = 1'b0;

    mem_arbiter_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .control_hazard(control_hazard), .io_buffer_full(io_buffer_full),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
        .slb_req(slb_req), .slb_addr(slb_addr), .slb_wr(slb_wr), .slb_dout(slb_dout),
        .slb_grant(slb_grant), .slb_din(slb_din),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_inst(if_inst)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk_in = ~clk_in;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- memory helpers ----------------
    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return 8'h00;
    endfunction

    function automatic logic [7:0] env_byte(input logic [31:0] a);
        if (env_mem.exists(a)) return env_mem[a];
        return 8'h00;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_byte(a + 32'd3), ref_byte(a + 32'd2), ref_byte(a + 32'd1), ref_byte(a)};
    endfunction

    task automatic mem_init(input logic [31:0] a, input logic [7:0] d);
        ref_mem[a] = d;
        env_mem[a] = d;
    endtask

    // RAM environment: read data appears the cycle after the address
    always @(posedge clk_in) begin
        ram_din <= env_byte(ram_a);
        if (ram_wr) env_mem[ram_a] = ram_dout;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk_in) slb_rd_pend <= !rst_in && slb_grant && !slb_wr;

    always @(negedge clk_in) begin
        if (if_valid) begin
            if (exp_inst_q.size() == 0) check("if_unexpected", {31'd0, if_valid}, 32'd0);
            else check("if_inst", if_inst, exp_inst_q.pop_front());
        end
        if (slb_rd_pend) begin
            if (exp_slb_q.size() == 0) check("slb_unexpected", {31'd0, slb_rd_pend}, 32'd0);
            else check("slb_din", {24'd0, slb_din}, {24'd0, exp_slb_q.pop_front()});
        end
    end

    // ---------------- driver tasks (entered and left at posedge+1) ----------------
    task automatic slb_access(input logic [31:0] a, input logic wr, input logic [7:0] d);
        logic granted;
        granted  = 1'b0;
        slb_req  = 1'b1;
        slb_addr = a;
        slb_wr   = wr;
        slb_dout = d;
        for (int i = 0; i < 50 && !granted; i++) begin
            @(negedge clk_in);
            if (slb_grant) begin
                granted = 1'b1;
                check("slb_ram_a", ram_a, a);
                check("slb_ram_wr", {31'd0, ram_wr}, {31'd0, wr});
                if (wr) begin
                    check("slb_ram_dout", {24'd0, ram_dout}, {24'd0, d});
                    ref_mem[a] = d;
                end else begin
                    exp_slb_q.push_back(ref_byte(a));
                end
            end
            @(posedge clk_in); #1;
        end
        slb_req = 1'b0;
        if (!granted) check("slb_grant_timeout", {31'd0, granted}, 32'd1);
    endtask

    task automatic rand_slb_op();
        logic [31:0] a;
        logic        wr;
        logic [7:0]  d;
        a  = 32'h400 + 32'($urandom_range(0, 31));
        wr = 1'($urandom_range(0, 1));
        d  = 8'($urandom_range(0, 255));
        slb_access(a, wr, d);
    endtask

    task automatic fetch_start(input logic [31:0] a, input bit push);
        if_req  = 1'b1;
        if_addr = a;
        if (push) exp_inst_q.push_back(ref_word(a));
    endtask

    task automatic wait_fetch_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk_in);
            if (if_valid) seen = 1'b1;
        end
        if (!seen) check("fetch_timeout", {31'd0, seen}, 32'd1);
        @(posedge clk_in); #1;
        if_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; control_hazard = 1'b0; io_buffer_full = 1'b0;
        slb_req = 1'b1; slb_wr = 1'b1; slb_addr = 32'h55; slb_dout = 8'h77;
        if_req = 1'b1; if_addr = 32'h100;

        mem_init(32'h100, 8'h13); mem_init(32'h101, 8'h05);
        mem_init(32'h102, 8'h00); mem_init(32'h103, 8'h00);
        mem_init(32'h200, 8'hEF); mem_init(32'h201, 8'hBE);
        mem_init(32'h202, 8'hAD); mem_init(32'h203, 8'hDE);
        for (int i = 0; i < 4; i++) begin
            mem_init(32'(i), 8'(8'h78 - 8'(i * 8'h22)));
            mem_init(32'h40 + 32'(i), 8'(8'hA0 + i));
            mem_init(32'h80 + 32'(i), 8'(8'hC0 + i));
            mem_init(32'h140 + 32'(i), 8'(8'h31 + 8'(i * 8'h11)));
            mem_init(32'h180 + 32'(i), 8'(8'h5A ^ 8'(i * 8'h27)));
            mem_init(32'h1C0 + 32'(i), 8'(8'hE0 + i));
        end

        // reset: outputs gated even with requests present
        @(posedge clk_in); @(posedge clk_in);
        @(negedge clk_in);
        check("rst_slb_grant", {31'd0, slb_grant}, 32'd0);
        check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        check("rst_ram_a", ram_a, 32'd0);
        check("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b0; slb_req = 1'b0; if_req = 1'b0;
        @(negedge clk_in);
        check("post_rst_if_inst", if_inst, 32'd0);
        check("post_rst_ram_a", ram_a, 32'd0);
        @(posedge clk_in); #1;

        // fetch only: 4 consecutive addresses then valid
        fetch_start(32'h100, 1'b1);
        @(negedge clk_in);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            check("fetch_ram_a", ram_a, 32'h100 + 32'(i));
            check("fetch_ram_wr", {31'd0, ram_wr}, 32'd0);
        end
        @(negedge clk_in);
        check("fetch_valid_latency", {31'd0, if_valid}, 32'd1);
        @(posedge clk_in); #1;
        if_req = 1'b0;
        @(posedge clk_in); #1;

        // LW at 0x200 as four byte loads
        for (int i = 0; i < 4; i++) slb_access(32'h200 + 32'(i), 1'b0, 8'h00);
        @(posedge clk_in); #1;

        // contention: SLB store wins, fetch follows
        fetch_start(32'h0, 1'b1);
        slb_access(32'h300, 1'b1, 8'hAA);
        @(negedge clk_in);
        check("contend_fetch_rd", {31'd0, ram_wr}, 32'd0);
        wait_fetch_done();
        slb_access(32'h300, 1'b0, 8'h00);
        @(posedge clk_in); #1;

        // flush after two bytes, restart at 0x40
        fetch_start(32'h80, 1'b0);
        @(negedge clk_in);
        @(negedge clk_in); check("flush_b0", ram_a, 32'h80);
        @(negedge clk_in); check("flush_b1", ram_a, 32'h81);
        @(posedge clk_in); #1;
        control_hazard = 1'b1;
        @(negedge clk_in);
        check("flush_no_grant", ram_a, 32'd0);
        check("flush_no_valid", {31'd0, if_valid}, 32'd0);
        @(posedge clk_in); #1;
        control_hazard = 1'b0;
        fetch_start(32'h40, 1'b1);
        @(negedge clk_in);
        @(negedge clk_in); check("flush_restart", ram_a, 32'h40);
        wait_fetch_done();
        @(posedge clk_in); #1;

        // pause for two cycles mid-fetch
        fetch_start(32'h140, 1'b1);
        @(negedge clk_in);
        @(negedge clk_in); check("rdy_b0", ram_a, 32'h140);
        @(negedge clk_in); check("rdy_b1", ram_a, 32'h141);
        @(posedge clk_in); #1;
        rdy_in = 1'b0; slb_req = 1'b1; slb_wr = 1'b0; slb_addr = 32'h200;
        @(negedge clk_in);
        check("rdy_no_ram_a", ram_a, 32'd0);
        check("rdy_no_slb_grant", {31'd0, slb_grant}, 32'd0);
        @(negedge clk_in);
        check("rdy_no_ram_a2", ram_a, 32'd0);
        @(posedge clk_in); #1;
        rdy_in = 1'b1; slb_req = 1'b0;
        @(negedge clk_in); check("rdy_resume_b2", ram_a, 32'h142);
        wait_fetch_done();
        @(posedge clk_in); #1;

        // reset mid-fetch: partial word dropped
        fetch_start(32'h1C0, 1'b0);
        repeat (3) @(negedge clk_in);
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        @(negedge clk_in);
        check("midrst_ram_a", ram_a, 32'd0);
        check("midrst_if_valid", {31'd0, if_valid}, 32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b0; if_req = 1'b0;
        repeat (6) begin @(posedge clk_in); #1; end

        // IO region store with the UART buffer full
`ifdef MEMCTRL_IO_GUARD_EN
        io_buffer_full = 1'b1;
        slb_req = 1'b1; slb_wr = 1'b1; slb_addr = 32'h30000; slb_dout = 8'h41;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            check("io_stall", {31'd0, slb_grant}, 32'd0);
        end
        @(posedge clk_in); #1;
        io_buffer_full = 1'b0;
        @(negedge clk_in);
        check("io_grant", {31'd0, slb_grant}, 32'd1);
        check("io_ram_a", ram_a, 32'h30000);
        ref_mem[32'h30000] = 8'h41;
        @(posedge clk_in); #1;
        slb_wr = 1'b0; slb_addr = 32'h200;
        @(negedge clk_in);
        check("io_idle_cycle", {31'd0, slb_grant}, 32'd0);
        @(posedge clk_in); #1;
        @(negedge clk_in);
        check("io_after_idle", {31'd0, slb_grant}, 32'd1);
        if (slb_grant) exp_slb_q.push_back(ref_byte(32'h200));
        @(posedge clk_in); #1;
        slb_req = 1'b0;
`else
        io_buffer_full = 1'b1;
        slb_req = 1'b1; slb_wr = 1'b1; slb_addr = 32'h30000; slb_dout = 8'h41;
        @(negedge clk_in);
        check("io_ignored", {31'd0, slb_grant}, 32'd1);
        if (slb_grant) ref_mem[32'h30000] = 8'h41;
        @(posedge clk_in); #1;
        slb_wr = 1'b0; slb_addr = 32'h200;
        @(negedge clk_in);
        check("io_no_idle", {31'd0, slb_grant}, 32'd1);
        if (slb_grant) exp_slb_q.push_back(ref_byte(32'h200));
        @(posedge clk_in); #1;
        slb_req = 1'b0; io_buffer_full = 1'b0;
`endif
        slb_access(32'h30000, 1'b0, 8'h00);

        // fetch interleaved with random SLB traffic
        fetch_start(32'h180, 1'b1);
        rand_slb_op();
        rand_slb_op();
        @(posedge clk_in); #1;
        rand_slb_op();
        wait_fetch_done();

        // random SLB burst
        for (int i = 0; i < 16; i++) begin
            rand_slb_op();
            repeat ($urandom_range(0, 2)) begin @(posedge clk_in); #1; end
        end

        repeat (4) begin @(posedge clk_in); #1; end
        check("inst_q_drained", 32'(exp_inst_q.size()), 32'd0);
        check("slb_q_drained", 32'(exp_slb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
